// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Applies the hazard unit's stall/flush requests to the front of the pipeline.
//   Drives the PC / IF/ID / ID/EX write enables and owns the IF/ID and ID/EX
//   valid bits, so inserted bubbles are real. A data-memory wait freezes the
//   whole pipeline. A watchdog flags long runs of consecutive stall cycles.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     defined   -> perf_stall / perf_flush / perf_freeze are saturating counters
//     undefined -> no counter flops; the three ports are tied to 0
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall_req                hazard unit: hold PC and IF/ID
//   flush_ifid_req           hazard unit: squash IF/ID (taken branch)
//   flush_idex_req           hazard unit: insert bubble into ID/EX
//   mem_busy                 data memory not ready: freeze everything
//   if_valid                 fetch stage holds a valid instruction
//   pc_we/ifid_we/idex_we    combinational write enables
//   ifid_valid/idex_valid    registered valid bits
//   ctrl_state               action of the previous cycle (0 RUN,1 STALL,2 FREEZE,3 FLUSH)
//   stall_timeout            sticky watchdog flag
//   perf_stall/flush/freeze  performance counters
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int CNT_W         = 32,
    parameter int WD_W          = 4,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             flush_ifid_req,
    input  logic             flush_idex_req,
    input  logic             mem_busy,
    input  logic             if_valid,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic [1:0]       ctrl_state,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_freeze
);

    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FREEZE = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    localparam logic [WD_W-1:0] WD_MAX   = '1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    act_e            act;
    act_e            ctrl_state_q, ctrl_state_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            idex_valid_q, idex_valid_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Action selection; a flush request under a stall is masked because the
    // branch resolved on stale operands and will re-resolve after the stall.
    always_comb begin
        act = ACT_RUN;
        if (mem_busy)            act = ACT_FREEZE;
        else if (stall_req)      act = ACT_STALL;
        else if (flush_ifid_req) act = ACT_FLUSH;
    end

    always_comb begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        if (!rst) begin
            case (act)
                ACT_FREEZE: ;
                ACT_STALL:  idex_we = flush_idex_req;  // bubble written into ID/EX
                default: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        idex_valid_d = idex_valid_q;
        wd_d         = wd_q;
        ctrl_state_d = act;
        case (act)
            ACT_FREEZE: ;
            ACT_STALL: begin
                if (flush_idex_req) idex_valid_d = 1'b0;
                if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
            end
            ACT_FLUSH: begin
                ifid_valid_d = 1'b0;
                idex_valid_d = ifid_valid_q & ~flush_idex_req;
                wd_d         = '0;
            end
            default: begin
                ifid_valid_d = if_valid;
                idex_valid_d = ifid_valid_q & ~flush_idex_req;
                wd_d         = '0;
            end
        endcase
        timeout_d = timeout_q | ((act == ACT_STALL) && (wd_d == WD_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            idex_valid_q <= 1'b0;
            ctrl_state_q <= ACT_RUN;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            idex_valid_q <= idex_valid_d;
            ctrl_state_q <= ctrl_state_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign idex_valid    = idex_valid_q;
    assign ctrl_state    = ctrl_state_q;
    assign stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic [CNT_W-1:0] perf_freeze_q, perf_freeze_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        perf_freeze_d = perf_freeze_q;
        if (act == ACT_STALL  && perf_stall_q  != CNT_MAX) perf_stall_d  = perf_stall_q  + 1'b1;
        if (act == ACT_FLUSH  && perf_flush_q  != CNT_MAX) perf_flush_d  = perf_flush_q  + 1'b1;
        if (act == ACT_FREEZE && perf_freeze_q != CNT_MAX) perf_freeze_d = perf_freeze_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_freeze_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
            perf_freeze_q <= perf_freeze_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_flush  = perf_flush_q;
    assign perf_freeze = perf_freeze_q;
`else
    assign perf_stall  = '0;
    assign perf_flush  = '0;
    assign perf_freeze = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, stall_req, flush_ifid_req, flush_idex_req, mem_busy, if_valid;
    logic pc_we, ifid_we, idex_we, ifid_valid, idex_valid, stall_timeout;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_freeze;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .WD_W(4), .STALL_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_ifid_req(flush_ifid_req),
        .flush_idex_req(flush_idex_req), .mem_busy(mem_busy), .if_valid(if_valid),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .ifid_valid(ifid_valid), .idex_valid(idex_valid), .ctrl_state(ctrl_state),
        .stall_timeout(stall_timeout), .perf_stall(perf_stall),
        .perf_flush(perf_flush), .perf_freeze(perf_freeze)
    );

    typedef struct {
        logic [2:0]  we;      // {pc, ifid, idex}
        logic        iv, xv, to;
        logic [1:0]  cs;
        logic [31:0] ps, pf, pz;
        bit          regs_known;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // reference state (value visible during the current cycle)
    bit          m_known = 0;
    logic        m_iv, m_xv, m_to;
    logic [1:0]  m_cs;
    int          m_wd;
    logic [31:0] m_ps, m_pf, m_pz;
    int          cyc_id = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, id, act, expv);
        end
    endtask

    // Issue one cycle of stimulus and push the expected response for it.
    task automatic cyc(input logic r, input logic st, input logic fi, input logic fx,
                       input logic mb, input logic ifv);
        exp_t e;
        @(posedge clk); #1;
        rst = r; stall_req = st; flush_ifid_req = fi; flush_idex_req = fx;
        mem_busy = mb; if_valid = ifv;
        e.id = cyc_id++;
        e.regs_known = m_known;
        e.iv = m_iv; e.xv = m_xv; e.cs = m_cs; e.to = m_to;
        e.ps = PERF_EN ? m_ps : 32'd0;
        e.pf = PERF_EN ? m_pf : 32'd0;
        e.pz = PERF_EN ? m_pz : 32'd0;
        if (r)       e.we = 3'b000;
        else if (mb) e.we = 3'b000;
        else if (st) e.we = {2'b00, fx};
        else         e.we = 3'b111;
        exp_q.push_back(e);
        // advance the reference to the state after this edge
        if (r) begin
            m_known = 1; m_iv = 0; m_xv = 0; m_cs = 2'd0; m_to = 0; m_wd = 0;
            m_ps = 0; m_pf = 0; m_pz = 0;
        end else if (mb) begin
            m_cs = 2'd2; m_pz++;
        end else if (st) begin
            m_cs = 2'd1; m_ps++;
            if (fx) m_xv = 0;
            m_wd = (m_wd < 15) ? m_wd + 1 : 15;
            if (m_wd == 15) m_to = 1;
        end else if (fi) begin
            m_cs = 2'd3; m_pf++;
            m_xv = fx ? 1'b0 : m_iv;
            m_iv = 0;
            m_wd = 0;
        end else begin
            m_cs = 2'd0;
            m_xv = fx ? 1'b0 : m_iv;
            m_iv = ifv;
            m_wd = 0;
        end
    endtask

    // monitor: every cycle the DUT presents a full output set; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we", e.id, {29'd0, pc_we, ifid_we, idex_we}, {29'd0, e.we});
                if (e.regs_known) begin
                    chk("ifid_valid", e.id, {31'd0, ifid_valid}, {31'd0, e.iv});
                    chk("idex_valid", e.id, {31'd0, idex_valid}, {31'd0, e.xv});
                    chk("ctrl_state", e.id, {30'd0, ctrl_state}, {30'd0, e.cs});
                    chk("stall_timeout", e.id, {31'd0, stall_timeout}, {31'd0, e.to});
                    chk("perf_stall", e.id, perf_stall, e.ps);
                    chk("perf_flush", e.id, perf_flush, e.pf);
                    chk("perf_freeze", e.id, perf_freeze, e.pz);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL time_limit reached got=running want=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst = 1; stall_req = 1; flush_ifid_req = 1; flush_idex_req = 1; mem_busy = 1; if_valid = 1;
        // 1: reset with every input high
        repeat (2) cyc(1, 1, 1, 1, 1, 1);
        // 2: fill the pipe
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // 3: stall with ID/EX bubble
        cyc(0, 1, 0, 1, 0, 1);
        // 4: masked flush, then real flush, then observe
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // flush with coincident ID/EX bubble, run with bubble, idle fetch, refill
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        // 5: freeze inside a stall run must hold the watchdog: 2 + 12 stalls -> 14, no timeout
        repeat (2) cyc(0, 1, 0, 0, 0, 1);
        repeat (4) cyc(0, 1, 1, 1, 1, 0);
        repeat (12) cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);            // clears watchdog
        cyc(0, 0, 0, 0, 0, 1);
        // 6: long stall trips the watchdog and saturates
        repeat (17) cyc(0, 1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // reset clears the sticky flag
        cyc(1, 0, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
